// File: rtl/accum_capture.sv
// Dump capture stage for the six early/prompt/late I/Q accumulators.
// Shadows one dump, flags unread data and overrun, counts epochs, and serves a registered read port.
module accum_capture #(
  parameter int ACC_W   = 16,
  parameter int NUM_ACC = 6,
  parameter int EPOCH_W = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     dump_enable,
  input  logic [NUM_ACC*ACC_W-1:0] acc_in,
  input  logic                     rd_en,
  input  logic [3:0]               rd_addr,
  output logic [31:0]              rd_data,
  output logic                     rd_valid,
  output logic                     new_data,
  output logic                     overrun,
  output logic [EPOCH_W-1:0]       epoch
);

  localparam logic [3:0] ADDR_STATUS = 4'd6;
  localparam logic [3:0] ADDR_DEBUG  = 4'd7;

  logic               dump_q;
  logic [ACC_W-1:0]   shadow_q [NUM_ACC];
  logic               new_data_q, new_data_d;
  logic               overrun_q, overrun_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic               rd_valid_q;
  logic               capture;
  logic               status_rd;
  logic [31:0]        status_word;

  // Accumulators present their result one edge after the dump strobe.
  assign capture   = dump_q;
  assign status_rd = rd_en && (rd_addr == ADDR_STATUS);

  always_comb begin
    status_word                = '0;
    status_word[8 +: EPOCH_W]  = epoch_q;
    status_word[1]             = overrun_q;
    status_word[0]             = new_data_q;
  end

  always_comb begin
    new_data_d = new_data_q;
    overrun_d  = overrun_q;
    epoch_d    = epoch_q;
    if (capture) begin
      new_data_d = 1'b1;
      epoch_d    = epoch_q + 1'b1;
    end else if (status_rd) begin
      new_data_d = 1'b0;
    end
    // A status read always wins over a coincident overrun.
    if (status_rd) begin
      overrun_d = 1'b0;
    end else if (capture && new_data_q) begin
      overrun_d = 1'b1;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = '0;
      if (rd_addr == ADDR_STATUS) begin
        rd_data_d = status_word;
      end else if (rd_addr == ADDR_DEBUG) begin
        rd_data_d = {31'b0, dump_q};
      end else begin
        for (int k = 0; k < NUM_ACC; k++) begin
          if (rd_addr == 4'(k)) begin
            rd_data_d = {{(32-ACC_W){shadow_q[k][ACC_W-1]}}, shadow_q[k]};
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dump_q     <= 1'b0;
      new_data_q <= 1'b0;
      overrun_q  <= 1'b0;
      epoch_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      for (int k = 0; k < NUM_ACC; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      dump_q     <= dump_enable;
      new_data_q <= new_data_d;
      overrun_q  <= overrun_d;
      epoch_q    <= epoch_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
      if (capture) begin
        for (int k = 0; k < NUM_ACC; k++) begin
          shadow_q[k] <= acc_in[k*ACC_W +: ACC_W];
        end
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign new_data = new_data_q;
  assign overrun  = overrun_q;
  assign epoch    = epoch_q;

endmodule
